// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle: raw bits in, conditioned vector and line status out.
interface sensor_conditioner_if;
    logic [3:0] sensor_raw;
    logic [3:0] sensor_clean;
    logic       change_strobe;
    logic [1:0] last_side;
    logic [1:0] line_state;
    logic       lost_line;

    modport master (
        output sensor_raw,
        input  sensor_clean,
        input  change_strobe,
        input  last_side,
        input  line_state,
        input  lost_line
    );

    modport slave (
        input  sensor_raw,
        output sensor_clean,
        output change_strobe,
        output last_side,
        output line_state,
        output lost_line
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Line-sensor front end: synchronise, debounce, remember the last side
// the line was seen on, and time out into LOST when the line disappears.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LOST_CYCLES     = 50000000
) (
    input logic clk,
    input logic rst,
    sensor_conditioner_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOST_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);

    typedef enum logic [1:0] {
        TRACK  = 2'b00,
        SEARCH = 2'b01,
        LOST   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        CENTER = 2'b11
    } side_t;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    clean;
    logic [3:0]    clean_next;
    logic [DW-1:0] cnt [4];
    logic [DW-1:0] cnt_next [4];
    logic          strobe;
    side_t         side;
    side_t         side_next;
    state_t        state;
    state_t        state_next;
    logic [LW-1:0] lost_cnt;
    logic [LW-1:0] lost_cnt_next;
    logic          lost_q;

    // A bit only flips after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        clean_next = clean;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != clean[i]) begin
                if (cnt[i] == DB_LAST) begin
                    clean_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        side_next = side;
        unique case (1'b1)
            clean == 4'b0000:
                side_next = side;
            clean[3:2] != 2'b00 && clean[1:0] == 2'b00:
                side_next = LEFT;
            clean[1:0] != 2'b00 && clean[3:2] == 2'b00:
                side_next = RIGHT;
            clean[1:0] != 2'b00 && clean[3:2] != 2'b00:
                side_next = CENTER;
            default:
                side_next = side;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cnt    <= '{default: '0};
            clean  <= '0;
            strobe <= 1'b0;
            side   <= NONE;
        end else begin
            sync1  <= bus.sensor_raw;
            sync2  <= sync1;
            cnt    <= cnt_next;
            clean  <= clean_next;
            strobe <= (clean_next != clean);
            side   <= side_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            lost_cnt <= '0;
            lost_q   <= 1'b0;
        end else begin
            state    <= state_next;
            lost_cnt <= lost_cnt_next;
            lost_q   <= (state_next == LOST);
        end
    end

    // A visible line always wins, even on the timeout edge.
    always_comb begin
        state_next    = state;
        lost_cnt_next = lost_cnt;
        if (clean != 4'b0000) begin
            state_next    = TRACK;
            lost_cnt_next = '0;
        end else begin
            unique case (state)
                TRACK: begin
                    state_next    = SEARCH;
                    lost_cnt_next = '0;
                end
                SEARCH: begin
                    if (lost_cnt == LOST_LAST) begin
                        state_next = LOST;
                    end else begin
                        lost_cnt_next = lost_cnt + 1'b1;
                    end
                end
                LOST: state_next = LOST;
                default: begin
                    state_next    = SEARCH;
                    lost_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.sensor_clean  = clean;
        bus.change_strobe = strobe;
        bus.last_side     = side;
        bus.line_state    = state;
        bus.lost_line     = lost_q;
    end
endmodule

// File: tb/tb_sensor_conditioner.sv
// Randomised bench for sensor_conditioner with a window-based reference
// model plus directed literal scenarios.
module tb_sensor_conditioner;
    localparam int DB = 4;
    localparam int LC = 10;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sensor_conditioner_if bus();

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .LOST_CYCLES(LC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Reference model
    logic [3:0] m_s1, m_s2, m_clean;
    logic       m_strobe, m_lost;
    logic [1:0] m_side, m_state;
    logic [3:0] hist[$];
    int         cyc, search_t;
    bit         model_on;
    int         strobes, losts;

    initial begin
        model_on = 0;
        cyc = 0;
        strobes = 0;
        losts = 0;
    end

    always @(posedge clk) begin
        logic [3:0] nc;
        bit all;
        if (model_on) begin
            if (bus.change_strobe) strobes++;
            if (bus.lost_line) losts++;
        end
        cyc++;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_clean = 0;
            m_strobe = 0; m_lost = 0;
            m_side = 2'd0; m_state = 2'd1;
            search_t = cyc;
            hist.delete();
            model_on = 1;
        end else if (model_on) begin
            hist.push_back(m_s2);
            nc = m_clean;
            if (hist.size() >= DB) begin
                for (int b = 0; b < 4; b++) begin
                    all = 1;
                    for (int k = 1; k <= DB; k++)
                        if (hist[hist.size()-k][b] == m_clean[b]) all = 0;
                    if (all) nc[b] = ~m_clean[b];
                end
            end
            if (hist.size() > DB) void'(hist.pop_front());
            m_strobe = (nc != m_clean);
            if (m_clean[3:2] != 0 && m_clean[1:0] == 0) m_side = 2'd1;
            else if (m_clean[1:0] != 0 && m_clean[3:2] == 0) m_side = 2'd2;
            else if (m_clean != 0) m_side = 2'd3;
            if (m_clean != 0) m_state = 2'd0;
            else if (m_state == 2'd0) begin
                m_state = 2'd1;
                search_t = cyc;
            end else if (m_state == 2'd1 && cyc - search_t >= LC)
                m_state = 2'd2;
            m_lost = (m_state == 2'd2);
            m_clean = nc;
            m_s2 = m_s1;
            m_s1 = bus.sensor_raw;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if ({bus.sensor_clean, bus.change_strobe, bus.last_side,
                 bus.line_state, bus.lost_line} !==
                {m_clean, m_strobe, m_side, m_state, m_lost}) begin
                failures++;
                if (failures <= 10)
                    $display("FAIL model t=%0t got c=%b s=%b side=%b st=%b l=%b want c=%b s=%b side=%b st=%b l=%b",
                             $time, bus.sensor_clean, bus.change_strobe,
                             bus.last_side, bus.line_state, bus.lost_line,
                             m_clean, m_strobe, m_side, m_state, m_lost);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    int s0, l0, r, k;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.sensor_raw = 4'b1111;
        step(2);
        chk("rst_clean", 8'(bus.sensor_clean), 8'h0);
        chk("rst_strobe", 8'(bus.change_strobe), 8'h0);
        chk("rst_side", 8'(bus.last_side), 8'h0);
        chk("rst_state", 8'(bus.line_state), 8'h1);
        chk("rst_lost", 8'(bus.lost_line), 8'h0);
        rst = 1'b0;
        step(5);
        chk("lat_before", 8'(bus.sensor_clean), 8'h0);
        step(1);
        chk("lat_clean", 8'(bus.sensor_clean), 8'hf);
        chk("lat_strobe", 8'(bus.change_strobe), 8'h1);
        step(1);
        chk("lat_strobe_end", 8'(bus.change_strobe), 8'h0);
        chk("lat_track", 8'(bus.line_state), 8'h0);
        chk("lat_side", 8'(bus.last_side), 8'h3);

        bus.sensor_raw = 4'b0110;
        step(8);
        chk("gl_base", 8'(bus.sensor_clean), 8'h6);
        s0 = strobes;
        bus.sensor_raw = 4'b0111;
        step(3);
        bus.sensor_raw = 4'b0110;
        step(8);
        chk("gl_clean", 8'(bus.sensor_clean), 8'h6);
        chk("gl_nostrobe", 8'(strobes - s0), 8'h0);
        bus.sensor_raw = 4'b0111;
        step(5);
        chk("gl_hold_pre", 8'(bus.sensor_clean), 8'h6);
        step(1);
        chk("gl_hold", 8'(bus.sensor_clean), 8'h7);

        bus.sensor_raw = 4'b1000;
        step(8);
        chk("side_left", 8'(bus.last_side), 8'h1);
        bus.sensor_raw = 4'b0000;
        step(8);
        chk("side_hold", 8'(bus.last_side), 8'h1);
        bus.sensor_raw = 4'b0001;
        step(8);
        chk("side_right", 8'(bus.last_side), 8'h2);
        bus.sensor_raw = 4'b0100;
        step(8);
        chk("side_left2", 8'(bus.last_side), 8'h1);

        bus.sensor_raw = 4'b0000;
        step(6);
        chk("loss_clean0", 8'(bus.sensor_clean), 8'h0);
        chk("loss_lag", 8'(bus.line_state), 8'h0);
        step(1);
        chk("loss_search", 8'(bus.line_state), 8'h1);
        step(9);
        chk("loss_pre", 8'(bus.line_state), 8'h1);
        chk("loss_pre_l", 8'(bus.lost_line), 8'h0);
        step(1);
        chk("loss_lost", 8'(bus.line_state), 8'h2);
        chk("loss_lost_l", 8'(bus.lost_line), 8'h1);
        bus.sensor_raw = 4'b0010;
        step(6);
        chk("rec_clean", 8'(bus.sensor_clean), 8'h2);
        chk("rec_lag", 8'(bus.lost_line), 8'h1);
        step(1);
        chk("rec_track", 8'(bus.line_state), 8'h0);
        chk("rec_lost", 8'(bus.lost_line), 8'h0);

        l0 = losts;
        bus.sensor_raw = 4'b0000;
        step(10);
        bus.sensor_raw = 4'b0010;
        step(6);
        chk("race_search", 8'(bus.line_state), 8'h1);
        chk("race_clean", 8'(bus.sensor_clean), 8'h2);
        step(1);
        chk("race_track", 8'(bus.line_state), 8'h0);
        chk("race_nolost", 8'(losts - l0), 8'h0);

        bus.sensor_raw = 4'b0000;
        step(11);
        bus.sensor_raw = 4'b1001;
        step(3);
        chk("mid_search", 8'(bus.line_state), 8'h1);
        rst = 1'b1;
        step(1);
        chk("mid_clean", 8'(bus.sensor_clean), 8'h0);
        chk("mid_side", 8'(bus.last_side), 8'h0);
        chk("mid_state", 8'(bus.line_state), 8'h1);
        chk("mid_lost", 8'(bus.lost_line), 8'h0);
        rst = 1'b0;
        bus.sensor_raw = 4'b0000;
        step(8);
        chk("mid_discard", 8'(bus.sensor_clean), 8'h0);

        repeat (400) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 2));
                rst = 1'b0;
            end else if (r < 4) begin
                bus.sensor_raw = 4'b0000;
                step($urandom_range(8, 20));
            end else if (r < 8) begin
                k = $urandom_range(0, 3);
                bus.sensor_raw[k] = ~bus.sensor_raw[k];
                step($urandom_range(1, 5));
                bus.sensor_raw[k] = ~bus.sensor_raw[k];
                step($urandom_range(1, 4));
            end else begin
                bus.sensor_raw = 4'($urandom);
                step($urandom_range(1, 8));
            end
        end
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
